update_packer: RTL and testbench
================================

UPDATE_PACKER -- requirements
Module: update_packer

Interface
REQ-001 SHALL have parameters: LANES, default 8, number of input lanes and output line width; WORD_W, default 64, payload bits per lane; BUF_DEPTH, default 16, staging slots, fixed at 2*LANES.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports word_in0..word_in7, input, 64 each, sorted payload lanes from the sort network.
REQ-005 SHALL have ports valid_in0..valid_in7, input, 1 each, per-lane valid; sorted so valid lanes occupy the highest lane indices.
REQ-006 SHALL have port word_in_valid, input, 1, the beat is present.
REQ-007 SHALL have port last_input_in, input, 1, final beat of a partition.
REQ-008 SHALL have port control_in, input, 2, sideband carried with the beat.
REQ-009 SHALL have port in_ready, output, 1, a beat is accepted when word_in_valid and in_ready are both 1.
REQ-010 SHALL have ports line_out0..line_out7, output, 64 each, packed output words.
REQ-011 SHALL have port line_mask, output, 8, per-word valid; bit k covers line_outk.
REQ-012 SHALL have port line_valid, output, 1, line present; port line_ready, input, 1, line accepted when both are 1.
REQ-013 SHALL have port line_last, output, 1, final line of the partition; port control_out, output, 2, control of the latest accepted beat at line formation.
REQ-014 SHALL have port order_err, output, 1, sticky flag for non-contiguous valid lanes.

Function
REQ-015 SHALL compute n = popcount(valid_in0..7) on each accepted beat and append lanes 8-n..7, in ascending lane order, to buffer slots cnt..cnt+n-1.
REQ-016 SHALL treat a beat with n=0 as accepted with no buffer change.
REQ-017 SHALL set order_err when an accepted beat has a valid lane below an invalid lane; the flag holds until rst, and packing still uses only the top n lanes.
REQ-018 SHALL drive in_ready = (state==RUN) and (cnt <= 7), using registered state only.
REQ-019 SHALL implement two states: RUN (accepting) and FLUSH (draining); RUN goes to FLUSH on an accepted beat with last_input_in=1; FLUSH goes to RUN when the line_last line is accepted.
REQ-020 SHALL form a full line when cnt >= 8 and the output register is free (line_valid=0, or line_ready=1 in the same cycle); line_mask=8'hFF, slots 0..7 are emitted, the remaining slots shift down by 8 and cnt decreases by 8.
REQ-021 SHALL, in FLUSH with 0 < cnt < 8, emit a partial line: mask = (1<<cnt)-1, unused words zero, line_last=1, cnt then 0.
REQ-022 SHALL, in FLUSH with cnt = 0 and no line pending, emit line_mask=0 and line_last=1.
REQ-023 SHALL set line_last=1 on a full line only if it drains the buffer to exactly 0 in FLUSH; the partition then ends without an extra empty line.
REQ-024 SHALL, on a simultaneous accept and emit, give next cnt = cnt - 8 + n; cnt never exceeds 15.
REQ-025 SHALL have latency of 2 cycles minimum: a beat accepted at edge t can appear in line_valid after edge t+1.
REQ-026 SHALL hold line_valid and all line fields stable while line_valid=1 and line_ready=0.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set cnt=0, state=RUN, line_valid=0, line_mask=0, line_last=0, line_out0..7=0, control_out=0 and order_err=0; any buffered or pending data is discarded, including mid-partition.
REQ-028 SHALL drive in_ready=1 in the cycle after reset is released.

Structure
REQ-029 SHALL place LANES, WORD_W, BUF_DEPTH and the RUN/FLUSH state encoding in the shared package used by the sort and update pipelines.
REQ-030 SHALL implement popcount and contiguity checking in one sub-module, lane_count8 (valid bits in; n and order-error out), combinational only.

Verification
REQ-031 SHALL cover: a beat with valid lanes 5..7 (A,B,C), then a beat with 5 valid lanes -> one line A,B,C then the next 5 words, mask FF; cnt returns to 0.
REQ-032 SHALL cover: 3 valid words then last_input_in=1 with 0 valid -> line mask 8'h07, words 3..7 zero, line_last=1; in_ready=0 until the line is accepted.
REQ-033 SHALL cover: line_ready=0 for 10 cycles with the buffer at 15 -> line fields stable, in_ready=0, and no word lost or duplicated after release.
REQ-034 SHALL cover: last beat with 0 valid on an empty buffer -> a single line with mask 0 and line_last=1.
REQ-035 SHALL cover: valid pattern 8'b1011_0000 -> order_err=1 and stays set; rst -> order_err=0.
REQ-036 SHALL cover: rst asserted in FLUSH with cnt=6 -> the next cycle has line_valid=0, in_ready=1, and a new partition packs from slot 0.

Source files
------------

// File: rtl/update_packer_pkg.sv
// Shared constants and state encoding for the sort and update pipelines.
package update_packer_pkg;
   localparam int LANES     = 8;
   localparam int WORD_W    = 64;
   localparam int BUF_DEPTH = 2 * LANES;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;
endpackage

// File: rtl/update_packer_lane_count8.sv
// Counts valid lanes of a sorted beat and flags a valid lane sitting below an invalid one.
module lane_count8
   import update_packer_pkg::*;
(
   input  logic [LANES-1:0] valid_bits,
   output logic [3:0]       n,
   output logic             order_err
);

   always_comb begin
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + {3'b000, valid_bits[i]};
      end
      // Any adjacent pair with lane i valid and lane i+1 invalid breaks contiguity.
      order_err = |(valid_bits[LANES-2:0] & ~valid_bits[LANES-1:1]);
   end

endmodule

// File: rtl/update_packer.sv
// Packs sorted, right-justified lane beats into full 8-word lines, with a
// partial (or empty) closing line per partition and a ready/valid output stage.
module update_packer
   import update_packer_pkg::*;
#(
   parameter int LANES     = update_packer_pkg::LANES,
   parameter int WORD_W    = update_packer_pkg::WORD_W,
   parameter int BUF_DEPTH = update_packer_pkg::BUF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] word_in0,
   input  logic [WORD_W-1:0] word_in1,
   input  logic [WORD_W-1:0] word_in2,
   input  logic [WORD_W-1:0] word_in3,
   input  logic [WORD_W-1:0] word_in4,
   input  logic [WORD_W-1:0] word_in5,
   input  logic [WORD_W-1:0] word_in6,
   input  logic [WORD_W-1:0] word_in7,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   input  logic              valid_in3,
   input  logic              valid_in4,
   input  logic              valid_in5,
   input  logic              valid_in6,
   input  logic              valid_in7,
   input  logic              word_in_valid,
   input  logic              last_input_in,
   input  logic [1:0]        control_in,
   output logic              in_ready,
   output logic [WORD_W-1:0] line_out0,
   output logic [WORD_W-1:0] line_out1,
   output logic [WORD_W-1:0] line_out2,
   output logic [WORD_W-1:0] line_out3,
   output logic [WORD_W-1:0] line_out4,
   output logic [WORD_W-1:0] line_out5,
   output logic [WORD_W-1:0] line_out6,
   output logic [WORD_W-1:0] line_out7,
   output logic [LANES-1:0]  line_mask,
   output logic              line_valid,
   input  logic              line_ready,
   output logic              line_last,
   output logic [1:0]        control_out,
   output logic              order_err
);

   localparam int                CNT_W   = $clog2(BUF_DEPTH);
   localparam int                LANE_W  = $clog2(LANES);
   localparam logic [CNT_W-1:0]  LANES_C = CNT_W'(LANES);

   logic [WORD_W-1:0] lanes [LANES];
   logic [LANES-1:0]  valid_vec;
   logic [3:0]        beat_n;
   logic              beat_order_err;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] buf_q [BUF_DEPTH];
   logic [WORD_W-1:0] buf_d [BUF_DEPTH];
   logic [WORD_W-1:0] line_q [LANES];
   logic [WORD_W-1:0] line_d [LANES];
   logic [LANES-1:0]  mask_q, mask_d;
   logic              line_valid_q, line_valid_d;
   logic              line_last_q, line_last_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [1:0]        control_q, control_d;
   logic              order_err_q, order_err_d;

   logic              accept, line_free, emit_full, emit_tail;
   logic [CNT_W-1:0]  base;

   assign lanes[0] = word_in0;
   assign lanes[1] = word_in1;
   assign lanes[2] = word_in2;
   assign lanes[3] = word_in3;
   assign lanes[4] = word_in4;
   assign lanes[5] = word_in5;
   assign lanes[6] = word_in6;
   assign lanes[7] = word_in7;
   assign valid_vec = {valid_in7, valid_in6, valid_in5, valid_in4,
                       valid_in3, valid_in2, valid_in1, valid_in0};

   lane_count8 u_lane_count (
      .valid_bits (valid_vec),
      .n          (beat_n),
      .order_err  (beat_order_err)
   );

   always_comb begin
      logic [CNT_W-1:0] slot;
      logic [CNT_W-1:0] lane_idx;

      // NOTE: every variable gets a default before any branch so no latch is inferred.
      in_ready  = (state_q == RUN) && (cnt_q < LANES_C);
      accept    = word_in_valid && in_ready;
      line_free = !line_valid_q || line_ready;
      emit_full = line_free && (cnt_q >= LANES_C);
      // The closing line is formed once per partition; a pending last line blocks another.
      emit_tail = line_free && (state_q == FLUSH) && (cnt_q < LANES_C)
                  && !(line_valid_q && line_last_q);

      if (emit_full)      base = cnt_q - LANES_C;
      else if (emit_tail) base = '0;
      else                base = cnt_q;

      buf_d = buf_q;
      if (emit_full) begin
         for (int i = 0; i < BUF_DEPTH - LANES; i++) buf_d[i] = buf_q[i + LANES];
      end
      slot     = '0;
      lane_idx = '0;
      for (int k = 0; k < LANES; k++) begin
         if (accept && (CNT_W'(k) < CNT_W'(beat_n))) begin
            slot     = base + CNT_W'(k);
            lane_idx = LANES_C - CNT_W'(beat_n) + CNT_W'(k);
            buf_d[slot] = lanes[lane_idx[LANE_W-1:0]];
         end
      end
      cnt_d = base + (accept ? CNT_W'(beat_n) : '0);

      line_d       = line_q;
      mask_d       = mask_q;
      line_last_d  = line_last_q;
      control_d    = control_q;
      line_valid_d = line_valid_q && !line_ready;
      if (emit_full) begin
         for (int i = 0; i < LANES; i++) line_d[i] = buf_q[i];
         mask_d       = '1;
         line_last_d  = (state_q == FLUSH) && (cnt_q == LANES_C);
         line_valid_d = 1'b1;
         control_d    = ctrl_q;
      end else if (emit_tail) begin
         for (int i = 0; i < LANES; i++) begin
            line_d[i] = (CNT_W'(i) < cnt_q) ? buf_q[i] : '0;
            mask_d[i] = (CNT_W'(i) < cnt_q);
         end
         line_last_d  = 1'b1;
         line_valid_d = 1'b1;
         control_d    = ctrl_q;
      end

      ctrl_d      = accept ? control_in : ctrl_q;
      order_err_d = order_err_q || (accept && beat_order_err);

      state_d = state_q;
      case (state_q)
         RUN:     if (accept && last_input_in) state_d = FLUSH;
         FLUSH:   if (line_valid_q && line_ready && line_last_q) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         cnt_q        <= '0;
         mask_q       <= '0;
         line_valid_q <= 1'b0;
         line_last_q  <= 1'b0;
         ctrl_q       <= '0;
         control_q    <= '0;
         order_err_q  <= 1'b0;
         for (int i = 0; i < LANES; i++) line_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         line_valid_q <= line_valid_d;
         line_last_q  <= line_last_d;
         ctrl_q       <= ctrl_d;
         control_q    <= control_d;
         order_err_q  <= order_err_d;
         line_q       <= line_d;
      end
   end

   // NOTE: staging slots are not reset; cnt_q alone decides which slots hold live data.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign line_out0   = line_q[0];
   assign line_out1   = line_q[1];
   assign line_out2   = line_q[2];
   assign line_out3   = line_q[3];
   assign line_out4   = line_q[4];
   assign line_out5   = line_q[5];
   assign line_out6   = line_q[6];
   assign line_out7   = line_q[7];
   assign line_mask   = mask_q;
   assign line_valid  = line_valid_q;
   assign line_last   = line_last_q;
   assign control_out = control_q;
   assign order_err   = order_err_q;

endmodule

// File: tb/tb_update_packer.sv
// Directed bench for update_packer: packing, partial/empty closing lines, stalls, order error, reset.
module tb_update_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] w [8];
   logic [7:0]  v;
   logic        word_in_valid, last_input_in, line_ready;
   logic [1:0]  control_in;
   logic        in_ready, line_valid, line_last, order_err;
   logic [63:0] lo [8];
   logic [7:0]  line_mask;
   logic [1:0]  control_out;

   logic [63:0] exp_w [8];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   update_packer dut (
      .clk(clk), .rst(rst),
      .word_in0(w[0]), .word_in1(w[1]), .word_in2(w[2]), .word_in3(w[3]),
      .word_in4(w[4]), .word_in5(w[5]), .word_in6(w[6]), .word_in7(w[7]),
      .valid_in0(v[0]), .valid_in1(v[1]), .valid_in2(v[2]), .valid_in3(v[3]),
      .valid_in4(v[4]), .valid_in5(v[5]), .valid_in6(v[6]), .valid_in7(v[7]),
      .word_in_valid(word_in_valid), .last_input_in(last_input_in),
      .control_in(control_in), .in_ready(in_ready),
      .line_out0(lo[0]), .line_out1(lo[1]), .line_out2(lo[2]), .line_out3(lo[3]),
      .line_out4(lo[4]), .line_out5(lo[5]), .line_out6(lo[6]), .line_out7(lo[7]),
      .line_mask(line_mask), .line_valid(line_valid), .line_ready(line_ready),
      .line_last(line_last), .control_out(control_out), .order_err(order_err)
   );

   function automatic logic [63:0] f(input int b, input int k);
      return {24'hA5C3E1, 8'(b), 24'h000000, 8'(k)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one beat at a negedge, hold until accepted, then drop word_in_valid.
   task automatic send(input int b, input logic [7:0] vb, input logic last, input logic [1:0] ctrl);
      int guard;
      for (int k = 0; k < 8; k++) w[k] = f(b, k);
      v             = vb;
      last_input_in = last;
      control_in    = ctrl;
      word_in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check($sformatf("in_ready_before_beat%0d", b), in_ready, 1'b1);
      @(negedge clk);
      word_in_valid = 1'b0;
      last_input_in = 1'b0;
      v             = 8'h00;
   endtask

   task automatic wait_line(input string tag, input logic [7:0] m, input logic l,
                            input logic [1:0] ctrl);
      int guard;
      guard = 0;
      while (!line_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_valid"}, line_valid, 1'b1);
      check({tag, "_mask"}, line_mask, m);
      check({tag, "_last"}, line_last, l);
      check({tag, "_ctrl"}, control_out, ctrl);
      for (int k = 0; k < 8; k++) check($sformatf("%s_word%0d", tag, k), lo[k], exp_w[k]);
   endtask

   task automatic accept_line();
      line_ready = 1'b1;
      @(negedge clk);
      line_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      word_in_valid = 1'b0; last_input_in = 1'b0; line_ready = 1'b0;
      control_in = 2'b00; v = 8'h00;
      for (int k = 0; k < 8; k++) w[k] = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_line_valid", line_valid, 1'b0);
      check("rst_line_mask", line_mask, 8'h00);
      check("rst_line_last", line_last, 1'b0);
      check("rst_order_err", order_err, 1'b0);
      check("rst_control", control_out, 2'b00);
      check("rst_word0", lo[0], 64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1'b1);

      // Three words then five words make exactly one full line.
      send(1, 8'hE0, 1'b0, 2'd1);
      send(2, 8'hF8, 1'b0, 2'd2);
      check("latency_no_line_yet", line_valid, 1'b0);
      exp_w = '{f(1,5), f(1,6), f(1,7), f(2,3), f(2,4), f(2,5), f(2,6), f(2,7)};
      wait_line("full1", 8'hFF, 1'b0, 2'd2);
      accept_line();
      check("full1_drained", line_valid, 1'b0);
      check("full1_in_ready", in_ready, 1'b1);

      // Three words then an empty last beat: partial line with mask 07.
      send(3, 8'hE0, 1'b0, 2'd0);
      send(4, 8'h00, 1'b1, 2'd1);
      check("flush_in_ready_low", in_ready, 1'b0);
      exp_w = '{f(3,5), f(3,6), f(3,7), 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
      wait_line("partial", 8'h07, 1'b1, 2'd1);
      @(negedge clk);
      check("partial_in_ready_held", in_ready, 1'b0);
      check("partial_hold_mask", line_mask, 8'h07);
      accept_line();
      check("partial_in_ready_back", in_ready, 1'b1);
      check("partial_no_extra", line_valid, 1'b0);

      // Stalled output with the buffer filled to 15.
      send(5, 8'hFF, 1'b0, 2'd3);
      send(6, 8'hFE, 1'b0, 2'd0);
      send(7, 8'hFF, 1'b0, 2'd2);
      for (int c = 0; c < 10; c++) begin
         check($sformatf("stall%0d_valid", c), line_valid, 1'b1);
         check($sformatf("stall%0d_mask", c), line_mask, 8'hFF);
         check($sformatf("stall%0d_w0", c), lo[0], f(5,0));
         check($sformatf("stall%0d_w7", c), lo[7], f(5,7));
         check($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
         @(negedge clk);
      end
      exp_w = '{f(5,0), f(5,1), f(5,2), f(5,3), f(5,4), f(5,5), f(5,6), f(5,7)};
      wait_line("stall_line1", 8'hFF, 1'b0, 2'd3);
      accept_line();
      exp_w = '{f(6,1), f(6,2), f(6,3), f(6,4), f(6,5), f(6,6), f(6,7), f(7,0)};
      wait_line("stall_line2", 8'hFF, 1'b0, 2'd2);
      accept_line();
      check("stall_in_ready_cnt7", in_ready, 1'b1);
      send(8, 8'h00, 1'b1, 2'd1);
      exp_w = '{f(7,1), f(7,2), f(7,3), f(7,4), f(7,5), f(7,6), f(7,7), 64'h0};
      wait_line("stall_tail", 8'h7F, 1'b1, 2'd1);
      accept_line();

      // Empty last beat on an empty buffer: one mask-0 closing line.
      send(9, 8'h00, 1'b1, 2'd0);
      exp_w = '{default: 64'h0};
      wait_line("empty", 8'h00, 1'b1, 2'd0);
      accept_line();
      check("empty_single_a", line_valid, 1'b0);
      @(negedge clk);
      check("empty_single_b", line_valid, 1'b0);
      check("empty_in_ready", in_ready, 1'b1);

      // A full line that drains the buffer in FLUSH is itself the last line.
      send(10, 8'hFF, 1'b1, 2'd2);
      exp_w = '{f(10,0), f(10,1), f(10,2), f(10,3), f(10,4), f(10,5), f(10,6), f(10,7)};
      wait_line("full_last", 8'hFF, 1'b1, 2'd2);
      accept_line();
      @(negedge clk);
      check("full_last_no_extra", line_valid, 1'b0);
      check("full_last_in_ready", in_ready, 1'b1);

      // Non-contiguous valid lanes, then reset in FLUSH with cnt=6.
      check("order_err_clear", order_err, 1'b0);
      send(11, 8'b1011_0000, 1'b0, 2'd0);
      check("order_err_set", order_err, 1'b1);
      send(12, 8'hE0, 1'b0, 2'd0);
      check("order_err_sticky", order_err, 1'b1);
      send(13, 8'h00, 1'b1, 2'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_flush_line_valid", line_valid, 1'b0);
      check("rst_flush_in_ready", in_ready, 1'b1);
      check("rst_flush_order_err", order_err, 1'b0);
      check("rst_flush_mask", line_mask, 8'h00);
      @(negedge clk);
      check("rst_flush_still_idle", line_valid, 1'b0);
      send(14, 8'hFF, 1'b0, 2'd1);
      exp_w = '{f(14,0), f(14,1), f(14,2), f(14,3), f(14,4), f(14,5), f(14,6), f(14,7)};
      wait_line("after_rst", 8'hFF, 1'b0, 2'd1);
      accept_line();
      check("after_rst_drained", line_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
